// File: rtl/io_uart_sched_pkg.sv
// Shared definitions for the IO-mapped UART transmit scheduler:
// status word bit positions and the emitter FSM state type.
package io_uart_sched_pkg;

    localparam int STAT_BUSY = 8;
    localparam int STAT_FULL = 9;
    localparam int STAT_OVF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset; pushes to a full FIFO
// and pops from an empty FIFO are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the pre-edge count, so a concurrent pop never rescues a push.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage carries no reset; the pointers and count alone define which
    // entries are live, so the array can map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: non-blocking assignments keep every register reading pre-edge values,
    // independent of statement order inside or across always_ff blocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_scheduler.sv
// IO-mapped UART transmit scheduler: byte FIFO feeding a valid/ready emitter.
// Define IO_UART_SCHED_OVF_EN to build the sticky overflow flag (status bit 10).
module io_uart_scheduler
    import io_uart_sched_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DAT_BIT  = 1,
    parameter int CNTL_BIT = 2
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [11:0] i_io_wordaddr,
    input  logic        i_io_wr,
    input  logic [31:0] i_io_wdata,
    output logic [31:0] o_io_rdata,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state;
    logic            wr_dat;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      fifo_head;
    logic [CW-1:0]   fifo_count;
    logic            ovf;
    logic            unused_bits;

    assign wr_dat = i_io_wr & i_io_wordaddr[DAT_BIT];

    // Pop whenever the output register is free or is being handed off this edge.
    assign fifo_pop = ~fifo_empty & ((state == ST_IDLE) | i_tx_ready);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_nrst),
        .push  (wr_dat),
        .pop   (fifo_pop),
        .wdata (i_io_wdata[7:0]),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state      <= ST_IDLE;
            o_tx_valid <= 1'b0;
            o_tx_data  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        o_tx_data  <= fifo_head;
                        o_tx_valid <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (i_tx_ready) begin
                        if (!fifo_empty) begin
                            o_tx_data <= fifo_head;
                        end else begin
                            o_tx_valid <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    o_tx_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IO_UART_SCHED_OVF_EN
    logic wr_cntl;
    assign wr_cntl = i_io_wr & i_io_wordaddr[CNTL_BIT];

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            ovf <= 1'b0;
        end else if (wr_dat && fifo_full) begin
            ovf <= 1'b1;
        end else if (wr_cntl && i_io_wdata[STAT_OVF]) begin
            ovf <= 1'b0;
        end
    end
`else
    assign ovf = 1'b0;
`endif

    // NOTE: the default assignment first guarantees every bit is driven on
    // every path, so no latch is inferred for the read mux.
    always_comb begin
        o_io_rdata = '0;
        if (i_io_wordaddr[CNTL_BIT]) begin
            o_io_rdata[CW-1:0]  = fifo_count;
            o_io_rdata[STAT_BUSY] = ~fifo_empty | (state == ST_SEND);
            o_io_rdata[STAT_FULL] = fifo_full;
            o_io_rdata[STAT_OVF]  = ovf;
        end
    end

    // Address and data bits outside the decoded fields are intentionally ignored.
    assign unused_bits = &{1'b0, i_io_wordaddr, i_io_wdata};

endmodule

// File: doc/io_uart_scheduler.md
IO_UART_SCHEDULER -- requirements
Module: io_uart_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the TX FIFO depth in bytes; it must be a power of two, at least 2.
REQ-002 Parameter DAT_BIT, default 1, SHALL be the one-hot word-address bit that selects the UART data register.
REQ-003 Parameter CNTL_BIT, default 2, SHALL be the one-hot word-address bit that selects the UART status/control register.
REQ-004 i_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 i_nrst  in  1  SHALL be the synchronous, active-low reset.
REQ-006 i_io_wordaddr  in  12  SHALL be the IO word address (memory address bits [13:2]), decoded one-hot.
REQ-007 i_io_wr  in  1  SHALL be the processor IO write strobe, valid for one cycle.
REQ-008 i_io_wdata  in  32  SHALL be the processor IO write data.
REQ-009 o_io_rdata  out  32  SHALL be the combinational read data.
REQ-010 o_tx_data  out  8  SHALL be the byte offered to the UART emitter.
REQ-011 o_tx_valid  out  1  SHALL be high while o_tx_data holds a valid byte.
REQ-012 i_tx_ready  in  1  SHALL be the emitter's accept/ready signal.

Function
REQ-013 A byte write SHALL occur when i_io_wr=1 and i_io_wordaddr[DAT_BIT]=1; i_io_wdata[7:0] is pushed into the FIFO unless the FIFO is full.
REQ-014 A byte write to a full FIFO SHALL be dropped, even if a pop happens in the same cycle.
REQ-015 The FSM SHALL have two states. IDLE: o_tx_valid=0. SEND: o_tx_valid=1.
REQ-016 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into the o_tx_data register and enter SEND on the same edge.
REQ-017 In SEND, a transfer SHALL complete on any edge where i_tx_ready=1.
REQ-018 On a completed transfer, if the FIFO is non-empty the FSM SHALL pop the next byte and stay in SEND (back-to-back, no idle cycle); otherwise it SHALL return to IDLE.
REQ-019 While in SEND without i_tx_ready, o_tx_data SHALL stay stable.
REQ-020 Latency: a byte written at edge N into an empty FIFO in IDLE SHALL appear with o_tx_valid=1 after edge N+1.
REQ-021 A push and a pop in the same cycle on a non-full, non-empty FIFO SHALL both occur, leaving the count unchanged.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; the count SHALL be log2(DEPTH)+1 bits wide.
REQ-023 When i_io_wordaddr[CNTL_BIT]=1, o_io_rdata SHALL return the status word:
- bit 9 = FIFO full
- bit 8 = busy (FIFO non-empty or state SEND)
- bits [log2(DEPTH):0] = FIFO count
- bit 10 = overflow (see REQ-029)
- all other bits 0
REQ-024 For all other addresses, including DAT, o_io_rdata SHALL be 0.
REQ-025 Writes with neither DAT_BIT nor CNTL_BIT set SHALL be ignored.

Reset
REQ-026 When i_nrst=0 at a clock edge, the block SHALL return to IDLE with an empty FIFO (pointers and count 0), o_tx_valid=0, o_tx_data=0 and overflow=0.
REQ-027 Reset mid-SEND SHALL discard the in-flight byte and all queued bytes; no transfer is counted on the reset edge.
REQ-028 FIFO storage SHALL need no reset.

Configuration
REQ-029 With IO_UART_SCHED_OVF_EN defined, a sticky overflow flag SHALL set on any dropped write; a CNTL write with i_io_wdata[10]=1 SHALL clear it, and set wins if both occur in the same cycle.
REQ-030 Without IO_UART_SCHED_OVF_EN, status bit 10 SHALL read 0, CNTL writes SHALL have no effect, and no flag logic is built.

Structure
REQ-031 Package io_uart_sched_pkg SHALL hold the status bit positions (FULL=9, BUSY=8, OVF=10) and the FSM state enum.
REQ-032 The FIFO SHALL be a sub-module, sync_fifo, parameterised by width 8 and DEPTH, exposing push, pop, full, empty and count.
REQ-033 The top level SHALL contain only the address decode, the FSM, the output register and the status mux.

Verification
REQ-034 Reset, then write 0x41 to DAT with i_tx_ready=1 -> o_tx_valid=1 with o_tx_data=0x41 one edge later, and back to IDLE the edge after.
REQ-035 i_tx_ready=0, write 0x01 to 0x05 (five bytes, DEPTH=4) -> first byte sits in the output register, the next four fill the FIFO, full=1, status=0x0000_0304; with OVF_EN, none dropped and bit 10=0.
REQ-036 Continue with a sixth write 0x06 -> byte dropped; status bit 10=1 with OVF_EN, 0 without; then a CNTL write of 0x400 -> bit 10=0.
REQ-037 Hold i_tx_ready=1 and queue 0x10, 0x11, 0x12 -> bytes emitted on consecutive cycles with o_tx_valid continuously high and no gaps.
REQ-038 Assert i_nrst=0 for one edge mid-SEND with 3 bytes queued -> o_tx_valid=0, status reads 0, and later writes restart cleanly from an empty FIFO.
